// File: rtl/vga_sync_receiver.sv
// VGA timing sink: registers the sync/DE/colour inputs, rebuilds pixel coordinates,
// measures line/frame geometry and tracks lock against the expected geometry.
module vga_sync_receiver #(
    parameter int H_DISP      = 640,
    parameter int V_DISP      = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter bit SYNC_LOW    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        disp_enable,
    input  logic        r,
    input  logic        g,
    input  logic        b,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic        pix_valid,
    output logic [2:0]  rgb_o,
    output logic        frame_start,
    output logic        locked,
    output logic        geom_err,
    output logic [15:0] meas_h_act,
    output logic [15:0] meas_v_act,
    output logic [15:0] meas_h_tot,
    output logic [15:0] meas_v_tot
);

    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;

    localparam logic [15:0] SAT       = 16'hFFFF;
    localparam logic [15:0] EXP_H_ACT = 16'(H_DISP);
    localparam logic [15:0] EXP_V_ACT = 16'(V_DISP);
    localparam logic [15:0] EXP_H_TOT = 16'(H_TOTAL);
    localparam logic [15:0] EXP_V_TOT = 16'(V_TOTAL);
    localparam logic [4:0]  LOCK_N    = 5'(LOCK_FRAMES);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == SAT) ? SAT : v + 16'd1;
    endfunction

    // input stage (syncs normalised to active-high) and previous sample for edges
    logic        hs_in_q, vs_in_q, de_in_q, hs_in_d, vs_in_d, de_in_d;
    logic [2:0]  rgb_in_q, rgb_in_d;
    logic        hs_prev_q, vs_prev_q, de_prev_q, hs_prev_d, vs_prev_d, de_prev_d;
    // counters and FSM
    logic [15:0] hcnt_q, lcnt_q, ycnt_q, hcnt_d, lcnt_d, ycnt_d;
    logic        bad_q, bad_d;
    logic [3:0]  match_q, match_d;
    state_t      state_q, state_d;
    // outputs
    logic [31:0] x_q, y_q, x_d, y_d;
    logic        pix_valid_q, pix_valid_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        frame_start_q, frame_start_d, locked_q, locked_d, geom_err_q, geom_err_d;
    logic [15:0] meas_h_act_q, meas_v_act_q, meas_h_tot_q, meas_v_tot_q;
    logic [15:0] meas_h_act_d, meas_v_act_d, meas_h_tot_d, meas_v_tot_d;

    logic        hs_lead, vs_lead, de_fall, de_rise, frame_bad, geom_ok;
    logic [15:0] run_len, h_act_new, h_tot_new, v_act_new, v_tot_new;
    logic [4:0]  match_inc;

    always_comb begin
        hs_in_d   = hsync ^ SYNC_LOW;
        vs_in_d   = vsync ^ SYNC_LOW;
        de_in_d   = disp_enable;
        rgb_in_d  = {r, g, b};
        hs_prev_d = hs_in_q;
        vs_prev_d = vs_in_q;
        de_prev_d = de_in_q;

        hs_lead = hs_in_q & ~hs_prev_q;
        vs_lead = vs_in_q & ~vs_prev_q;
        de_fall = de_prev_q & ~de_in_q;
        de_rise = de_in_q & ~de_prev_q;

        // x_q still holds the last pixel of the run when the fall is seen
        run_len   = (x_q[31:16] != 16'd0 || x_q[15:0] == SAT) ? SAT : x_q[15:0] + 16'd1;
        h_act_new = de_fall ? run_len : meas_h_act_q;
        h_tot_new = hs_lead ? sat_inc(hcnt_q) : meas_h_tot_q;
        v_act_new = de_fall ? sat_inc(ycnt_q) : ycnt_q;
        // an hsync edge coincident with vsync belongs to the frame being closed
        v_tot_new = hs_lead ? sat_inc(lcnt_q) : lcnt_q;

        frame_bad = bad_q || (de_fall && run_len != EXP_H_ACT) ||
                    (hcnt_q == SAT) || (lcnt_q == SAT);
        geom_ok   = !frame_bad && h_act_new == EXP_H_ACT && v_act_new == EXP_V_ACT &&
                    h_tot_new == EXP_H_TOT && v_tot_new == EXP_V_TOT;

        hcnt_d = hs_lead ? 16'd0 : sat_inc(hcnt_q);
        lcnt_d = vs_lead ? 16'd0 : v_tot_new;
        ycnt_d = vs_lead ? 16'd0 : v_act_new;
        bad_d  = vs_lead ? 1'b0 : frame_bad;

        meas_h_act_d = h_act_new;
        meas_h_tot_d = h_tot_new;
        meas_v_act_d = vs_lead ? v_act_new : meas_v_act_q;
        meas_v_tot_d = vs_lead ? v_tot_new : meas_v_tot_q;

        pix_valid_d = de_in_q;
        rgb_d = de_in_q ? rgb_in_q : rgb_q;
        x_d   = de_in_q ? (de_rise ? 32'd0 : x_q + 32'd1) : x_q;
        y_d   = de_in_q ? {16'd0, (vs_lead ? 16'd0 : ycnt_q)} : y_q;

        state_d    = state_q;
        match_d    = match_q;
        geom_err_d = 1'b0;
        match_inc  = {1'b0, match_q} + 5'd1;
        if (vs_lead) begin
            case (state_q)
                SEARCH: begin
                    state_d = MEASURE;
                    match_d = 4'd0;
                end
                MEASURE: begin
                    if (geom_ok) begin
                        state_d = (LOCK_N <= 5'd1) ? LOCKED : CHECK;
                        match_d = 4'd1;
                    end else begin
                        geom_err_d = 1'b1;
                    end
                end
                CHECK: begin
                    if (geom_ok) begin
                        match_d = match_inc[3:0];
                        if (match_inc >= LOCK_N) state_d = LOCKED;
                    end else begin
                        geom_err_d = 1'b1;
                        state_d    = SEARCH;
                        match_d    = 4'd0;
                    end
                end
                default: begin
                    if (!geom_ok) begin
                        geom_err_d = 1'b1;
                        state_d    = SEARCH;
                        match_d    = 4'd0;
                    end
                end
            endcase
        end
        locked_d      = (state_d == LOCKED);
        frame_start_d = vs_lead;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_in_q <= 1'b0; vs_in_q <= 1'b0; de_in_q <= 1'b0; rgb_in_q <= 3'd0;
            hs_prev_q <= 1'b0; vs_prev_q <= 1'b0; de_prev_q <= 1'b0;
            hcnt_q <= 16'd0; lcnt_q <= 16'd0; ycnt_q <= 16'd0;
            bad_q <= 1'b0; match_q <= 4'd0; state_q <= SEARCH;
            x_q <= 32'd0; y_q <= 32'd0; pix_valid_q <= 1'b0; rgb_q <= 3'd0;
            frame_start_q <= 1'b0; locked_q <= 1'b0; geom_err_q <= 1'b0;
            meas_h_act_q <= 16'd0; meas_v_act_q <= 16'd0;
            meas_h_tot_q <= 16'd0; meas_v_tot_q <= 16'd0;
        end else begin
            hs_in_q <= hs_in_d; vs_in_q <= vs_in_d; de_in_q <= de_in_d; rgb_in_q <= rgb_in_d;
            hs_prev_q <= hs_prev_d; vs_prev_q <= vs_prev_d; de_prev_q <= de_prev_d;
            hcnt_q <= hcnt_d; lcnt_q <= lcnt_d; ycnt_q <= ycnt_d;
            bad_q <= bad_d; match_q <= match_d; state_q <= state_d;
            x_q <= x_d; y_q <= y_d; pix_valid_q <= pix_valid_d; rgb_q <= rgb_d;
            frame_start_q <= frame_start_d; locked_q <= locked_d; geom_err_q <= geom_err_d;
            meas_h_act_q <= meas_h_act_d; meas_v_act_q <= meas_v_act_d;
            meas_h_tot_q <= meas_h_tot_d; meas_v_tot_q <= meas_v_tot_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pix_valid   = pix_valid_q;
    assign rgb_o       = rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign geom_err    = geom_err_q;
    assign meas_h_act  = meas_h_act_q;
    assign meas_v_act  = meas_v_act_q;
    assign meas_h_tot  = meas_h_tot_q;
    assign meas_v_tot  = meas_v_tot_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled 8x6 (14x10 total) raster.
// DUT 0: active-low syncs, DUT 1: active-high syncs, DUT 2: active-low with single-frame lock.
module tb_vga_sync_receiver;
    localparam int HD = 8, HT = 14, VD = 6, VT = 10;

    logic clk = 1'b0, rst_n = 1'b1;
    logic hs_a = 1'b0, vs_a = 1'b0, de = 1'b0;
    logic [2:0] rgb_i = 3'd0;

    logic [31:0] x_o [3], y_o [3];
    logic        pv_o [3], fs_o [3], lk_o [3], ge_o [3];
    logic [2:0]  rgb_w [3];
    logic [15:0] mha [3], mva [3], mht [3], mvt [3];

    always #5 clk = ~clk;

    vga_sync_receiver #(.H_DISP(HD), .V_DISP(VD), .H_TOTAL(HT), .V_TOTAL(VT),
                        .SYNC_LOW(1'b1), .LOCK_FRAMES(2)) u_lo (
        .clk(clk), .rst_n(rst_n), .hsync(~hs_a), .vsync(~vs_a), .disp_enable(de),
        .r(rgb_i[2]), .g(rgb_i[1]), .b(rgb_i[0]), .x(x_o[0]), .y(y_o[0]),
        .pix_valid(pv_o[0]), .rgb_o(rgb_w[0]), .frame_start(fs_o[0]), .locked(lk_o[0]),
        .geom_err(ge_o[0]), .meas_h_act(mha[0]), .meas_v_act(mva[0]),
        .meas_h_tot(mht[0]), .meas_v_tot(mvt[0]));

    vga_sync_receiver #(.H_DISP(HD), .V_DISP(VD), .H_TOTAL(HT), .V_TOTAL(VT),
                        .SYNC_LOW(1'b0), .LOCK_FRAMES(2)) u_hi (
        .clk(clk), .rst_n(rst_n), .hsync(hs_a), .vsync(vs_a), .disp_enable(de),
        .r(rgb_i[2]), .g(rgb_i[1]), .b(rgb_i[0]), .x(x_o[1]), .y(y_o[1]),
        .pix_valid(pv_o[1]), .rgb_o(rgb_w[1]), .frame_start(fs_o[1]), .locked(lk_o[1]),
        .geom_err(ge_o[1]), .meas_h_act(mha[1]), .meas_v_act(mva[1]),
        .meas_h_tot(mht[1]), .meas_v_tot(mvt[1]));

    vga_sync_receiver #(.H_DISP(HD), .V_DISP(VD), .H_TOTAL(HT), .V_TOTAL(VT),
                        .SYNC_LOW(1'b1), .LOCK_FRAMES(1)) u_lf1 (
        .clk(clk), .rst_n(rst_n), .hsync(~hs_a), .vsync(~vs_a), .disp_enable(de),
        .r(rgb_i[2]), .g(rgb_i[1]), .b(rgb_i[0]), .x(x_o[2]), .y(y_o[2]),
        .pix_valid(pv_o[2]), .rgb_o(rgb_w[2]), .frame_start(fs_o[2]), .locked(lk_o[2]),
        .geom_err(ge_o[2]), .meas_h_act(mha[2]), .meas_v_act(mva[2]),
        .meas_h_tot(mht[2]), .meas_v_tot(mvt[2]));

    typedef struct packed {
        logic        de;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  c;
        logic        chk;
    } pix_t;

    pix_t h0 = '0, h1 = '0, last = '0;
    int   checks = 0, failures = 0, exp_fs = 0, exp_ge = 0;
    int   fs_cnt [3], ge_cnt [3];
    bit   pix_ok = 1'b0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel clock: sample outputs for the input driven two cycles ago, then drive.
    task automatic tick(input logic hs, input logic vs, input logic d, input logic [2:0] c,
                        input logic [31:0] px, input logic [31:0] py);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (fs_o[i]) fs_cnt[i]++;
            if (ge_o[i]) ge_cnt[i]++;
        end
        if (h1.de) last = h1;
        if (h1.chk)
            for (int i = 0; i < 3; i++)
                chk($sformatf("pix%0d", i), {pv_o[i], x_o[i], y_o[i], rgb_w[i]},
                    {h1.de, last.x, last.y, last.c});
        h1 = h0;
        h0 = '{de: d, x: px, y: py, c: c, chk: pix_ok};
        hs_a = hs; vs_a = vs; de = d; rgb_i = c;
    endtask

    task automatic frame_part(input bit align, input bit bad, input int from, input int to);
        for (int idx = from; idx < to; idx++) begin
            int   ln, col, vst;
            logic d, hs, vs;
            ln  = idx / HT;
            col = idx % HT;
            vst = 7 * HT + (align ? HD + 2 : 0);
            d   = (ln < VD) && (col < ((bad && ln == 2) ? HD - 1 : HD));
            hs  = (col >= HD + 2) && (col < HD + 4);
            vs  = (idx >= vst) && (idx < vst + 2 * HT);
            tick(hs, vs, d, 3'((col + 3 * ln) % 8), 32'(col), 32'(ln));
        end
    endtask

    task automatic frame(input bit align, input bit bad);
        frame_part(align, bad, 0, HT * VT);
        exp_fs++;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        h0.chk = 1'b0; h1.chk = 1'b0; last = '0; pix_ok = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst_zero%0d", i),
                {x_o[i], y_o[i], pv_o[i], rgb_w[i], fs_o[i], lk_o[i], ge_o[i],
                 mha[i], mva[i], mht[i], mvt[i]}, 160'd0);
        repeat (n) tick(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
    endtask

    // lk bit i is the expected locked value of DUT i
    task automatic state_chk(input string tag, input logic [2:0] lk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_lock%0d", tag, i), lk_o[i], lk[i]);
            chk($sformatf("%s_fs%0d", tag, i), fs_cnt[i], exp_fs);
            chk($sformatf("%s_ge%0d", tag, i), ge_cnt[i], exp_ge);
        end
    endtask

    task automatic meas_chk(input string tag, input logic [15:0] ha, input logic [15:0] va,
                            input logic [15:0] ht, input logic [15:0] vt);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s_meas%0d", tag, i), {mha[i], mva[i], mht[i], mvt[i]},
                {ha, va, ht, vt});
    endtask

    initial begin
        fs_cnt = '{0, 0, 0};
        ge_cnt = '{0, 0, 0};
        #2;
        do_reset(4);
        pix_ok = 1'b1;

        // clean frames: lock on the third vsync edge (second for single-frame lock)
        frame(1'b0, 1'b0); state_chk("f1", 3'b000);
        frame(1'b0, 1'b0); state_chk("f2", 3'b100); meas_chk("f2", 16'd8, 16'd6, 16'd14, 16'd10);
        frame(1'b0, 1'b0); state_chk("f3", 3'b111); meas_chk("f3", 16'd8, 16'd6, 16'd14, 16'd10);

        // one short DE line drops lock at the next vsync, then relock
        frame(1'b0, 1'b1); exp_ge++; state_chk("f4_bad", 3'b000);
        frame(1'b0, 1'b0); state_chk("f5", 3'b000);
        frame(1'b0, 1'b0); state_chk("f6", 3'b100);
        frame(1'b0, 1'b0); state_chk("f7", 3'b111);

        // hsync lost for longer than the counter range
        pix_ok = 1'b0;
        repeat (70000) tick(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        pix_ok = 1'b1;
        frame_part(1'b0, 1'b0, 0, HT);
        for (int i = 0; i < 3; i++) chk($sformatf("hsat%0d", i), mht[i], 16'hFFFF);
        frame_part(1'b0, 1'b0, HT, HT * VT); exp_fs++; exp_ge++;
        state_chk("f8_sat", 3'b000);
        frame(1'b0, 1'b0); state_chk("f9", 3'b000);
        frame(1'b0, 1'b0); state_chk("f10", 3'b100);
        frame(1'b0, 1'b0); state_chk("f11", 3'b111);

        // reset in the middle of an active line; the partial frame is ignored
        frame_part(1'b0, 1'b0, 0, 3 * HT + 5);
        do_reset(3);
        frame_part(1'b0, 1'b0, 3 * HT + 5, HT * VT); exp_fs++;
        state_chk("f12_rst", 3'b000);
        pix_ok = 1'b1;
        frame(1'b0, 1'b0); state_chk("f13", 3'b100);
        frame(1'b0, 1'b0); state_chk("f14", 3'b111);

        // vsync edge coincident with an hsync edge
        do_reset(3);
        pix_ok = 1'b1;
        frame(1'b1, 1'b0); state_chk("a1", 3'b000);
        frame(1'b1, 1'b0); state_chk("a2", 3'b100);
        frame(1'b1, 1'b0); state_chk("a3", 3'b111); meas_chk("a3", 16'd8, 16'd6, 16'd14, 16'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
